// File: rtl/debug_probe_unit.sv
// Debug probe unit: byte-command port that reads probe channels and halts/steps the CPU.
// Latency: first response byte is valid the cycle after command accept, then one byte per cycle.
// Backpressure: tx_ready low holds tx_data; cmd_ready only while idle. Optional READ checksum: DBG_PROBE_CRC_EN.
module debug_probe_unit #(
    parameter int NCH    = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH*DATA_W-1:0] probe_data,
    input  logic [7:0]            cmd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  cpu_halt,
    output logic                  cpu_step
);
    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 2);

`ifdef DBG_PROBE_CRC_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CRC = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
`endif

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                halt_q, halt_d;
    logic                step_q, step_d;
`ifdef DBG_PROBE_CRC_EN
    logic [7:0]          crc_q, crc_d;
    logic                is_read_q, is_read_d;
`endif

    logic                cmd_accept;
    logic                tx_fire;
    logic                is_read_cmd;
    logic                is_ctrl_cmd;
    logic [DATA_W-1:0]   probe_sel;

    assign cmd_ready   = (state_q == IDLE);
    assign tx_valid    = (state_q != IDLE);
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign tx_fire     = tx_valid && tx_ready;
    assign is_read_cmd = (cmd_data[7:6] == 2'b00);
    assign is_ctrl_cmd = (cmd_data == 8'h40) || (cmd_data == 8'h41) || (cmd_data == 8'h42);
    assign cpu_halt    = halt_q;
    assign cpu_step    = step_q;

    // Channels beyond NCH never match, so out-of-range indices capture zero.
    always_comb begin
        probe_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cmd_data[5:0] == 6'(k)) begin
                probe_sel = probe_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d = SEND;
                    if (is_read_cmd) begin
                        shift_d = probe_sel;
                        cnt_d   = CNT_W'(NBYTES);
                    end else begin
                        cnt_d   = CNT_W'(1);
                        shift_d = '0;
                        if (cmd_data == 8'h40) halt_d = 1'b1;
                        if (cmd_data == 8'h41) halt_d = 1'b0;
                        if (cmd_data == 8'h42) step_d = halt_q;
                        // Single-byte replies ride in the top byte of the shift register.
                        if (is_ctrl_cmd) shift_d[DATA_W-1 -: 8] = {7'b0101_000, halt_d};
                        else             shift_d[DATA_W-1 -: 8] = 8'hEE;
                    end
                end
            end
            SEND: begin
                if (tx_fire) begin
                    shift_d = shift_q << 8;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
`ifdef DBG_PROBE_CRC_EN
                        state_d = is_read_q ? CRC : IDLE;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef DBG_PROBE_CRC_EN
            CRC: begin
                if (tx_fire) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef DBG_PROBE_CRC_EN
    always_comb begin
        crc_d     = crc_q;
        is_read_d = is_read_q;
        if (state_q == IDLE && cmd_accept) begin
            crc_d     = '0;
            is_read_d = is_read_cmd;
        end else if (state_q == SEND && tx_fire) begin
            crc_d = crc_q ^ shift_q[DATA_W-1 -: 8];
        end
    end
`endif

    always_comb begin
        tx_data = 8'h00;
        if (state_q == SEND) tx_data = shift_q[DATA_W-1 -: 8];
`ifdef DBG_PROBE_CRC_EN
        if (state_q == CRC)  tx_data = crc_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            halt_q    <= 1'b0;
            step_q    <= 1'b0;
`ifdef DBG_PROBE_CRC_EN
            crc_q     <= '0;
            is_read_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            halt_q    <= halt_d;
            step_q    <= step_d;
`ifdef DBG_PROBE_CRC_EN
            crc_q     <= crc_d;
            is_read_q <= is_read_d;
`endif
        end
    end

endmodule

// File: tb/tb_debug_probe_unit.sv
// Directed plus randomized bench for debug_probe_unit against a byte-list reference model.
module tb_debug_probe_unit;
    localparam int NCH = 8;
    localparam int DW  = 32;
    localparam int NB  = DW / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*DW-1:0] probe_data;
    logic [7:0]        cmd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              cpu_halt;
    logic              cpu_step;

    int          vectors     = 0;
    int          miscompares = 0;
    logic        halt_m;
    logic        step_m;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    debug_probe_unit #(.NCH(NCH), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .probe_data (probe_data),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .cpu_halt   (cpu_halt),
        .cpu_step   (cpu_step)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_probes();
        for (int k = 0; k < NCH; k++) probe_data[k*DW +: DW] = $urandom;
    endtask

    // Expected response bytes for a command, from the command table.
    task automatic model_cmd(input logic [7:0] c);
        logic [DW-1:0] word;
        logic [7:0]    sum;
        int            idx;
        exp_q.delete();
        step_m = 1'b0;
        if (c[7:6] == 2'b00) begin
            idx  = int'(c[5:0]);
            word = '0;
            if (idx < NCH) word = probe_data[idx*DW +: DW];
            sum = 8'h00;
            for (int b = NB - 1; b >= 0; b--) begin
                exp_q.push_back(word[b*8 +: 8]);
                sum = sum ^ word[b*8 +: 8];
            end
`ifdef DBG_PROBE_CRC_EN
            exp_q.push_back(sum);
`endif
        end else if (c == 8'h40) begin
            halt_m = 1'b1;
            exp_q.push_back(8'h51);
        end else if (c == 8'h41) begin
            halt_m = 1'b0;
            exp_q.push_back(8'h50);
        end else if (c == 8'h42) begin
            step_m = halt_m;
            exp_q.push_back(halt_m ? 8'h51 : 8'h50);
        end else begin
            exp_q.push_back(8'hEE);
        end
    endtask

    // Starts and ends at a falling edge; first_stall >= 0 fixes the wait before byte 0.
    task automatic run_cmd(input logic [7:0] c, input int first_stall, input bit rnd_stall);
        int waits;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        check("tx_valid_idle", 64'(tx_valid), 64'd0);
        model_cmd(c);
        cmd_data  = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        randomize_probes();
        check("cpu_halt", 64'(cpu_halt), 64'(halt_m));
        check("cpu_step_pulse", 64'(cpu_step), 64'(step_m));
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 0 && first_stall >= 0) waits = first_stall;
            else waits = rnd_stall ? int'($urandom_range(0, 3)) : 0;
            for (int w = 0; w <= waits; w++) begin
                check("tx_valid", 64'(tx_valid), 64'd1);
                check("tx_data", 64'(tx_data), 64'(exp_q[i]));
                if (i != 0 || w != 0) check("cpu_step_low", 64'(cpu_step), 64'd0);
                tx_ready = (w == waits);
                @(posedge clk);
                @(negedge clk);
            end
        end
        tx_ready = 1'b0;
        check("tx_valid_done", 64'(tx_valid), 64'd0);
        check("cmd_ready_done", 64'(cmd_ready), 64'd1);
        check("cpu_step_done", 64'(cpu_step), 64'd0);
    endtask

    task automatic set_ch3();
        probe_data[3*DW +: DW] = 32'h1234_5678;
    endtask

    initial begin
        logic [7:0] c;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_data   = 8'h00;
        tx_ready   = 1'b0;
        probe_data = '0;
        halt_m     = 1'b0;
        step_m     = 1'b0;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_cpu_halt", 64'(cpu_halt), 64'd0);
        check("rst_cpu_step", 64'(cpu_step), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        randomize_probes();
        set_ch3();
        run_cmd(8'h03, 0, 1'b0);
        run_cmd(8'h0A, 0, 1'b0);
        run_cmd(8'h42, 0, 1'b0);
        run_cmd(8'h40, 0, 1'b0);
        run_cmd(8'h42, 0, 1'b0);
        set_ch3();
        run_cmd(8'h03, 5, 1'b0);
        run_cmd(8'h7F, 0, 1'b0);
        run_cmd(8'h41, 0, 1'b0);
        run_cmd(8'h42, -1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    c = 8'($urandom_range(0, NCH - 1));
                2:       c = 8'($urandom_range(NCH, 63));
                3:       c = 8'h40;
                4:       c = 8'($urandom_range(8'h41, 8'h42));
                default: c = 8'($urandom);
            endcase
            randomize_probes();
            run_cmd(c, -1, 1'b1);
        end

        // Abort a READ mid-response while halted.
        run_cmd(8'h40, 0, 1'b0);
        set_ch3();
        model_cmd(8'h03);
        cmd_data  = 8'h03;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        tx_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("abort_tx_data", 64'(tx_data), 64'(exp_q[i]));
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        halt_m = 1'b0;
        check("abort_tx_valid", 64'(tx_valid), 64'd0);
        check("abort_cpu_halt", 64'(cpu_halt), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        check("abort_tx_data0", 64'(tx_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_bytes", 64'(tx_valid), 64'd0);
        end
        tx_ready = 1'b0;

        // Command offered in the same cycle reset releases.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        set_ch3();
        run_cmd(8'h03, 0, 1'b0);
        run_cmd(8'h42, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
